alu_bist: RTL and testbench
===========================

# alu_bist

Built-in self-test engine for the 8-bit ALU family. It generates a pseudo-random operand/opcode sequence, drives it to two ALU instances (implementation under test and behavioural reference), and samples both instances' result and NZVC outputs one cycle later. It compares the two sets of outputs and reports an error count, the first failing vector, and pass/done status. It sits beside the ALU pair in silicon-level regression builds and replaces the manual stimulus/compare loop with a self-contained sequential checker.

## Interface
- NUM_VECTORS, 256, vectors per run; legal range 1..65535
- SEED, 16'hACE1, LFSR load value; must be nonzero
- CNT_W, 8, width of the saturating error counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled in IDLE and DONE only
- a_o  out  8  operand A to both ALUs (registered)
- b_o  out  8  operand B to both ALUs (registered)
- sel_o  out  3  opcode to both ALUs (registered)
- r_dut_i  in  8  result of the ALU under test
- f_dut_i  in  4  NZVC of the ALU under test; bit3=N, bit2=Z, bit1=V, bit0=C
- r_ref_i  in  8  result of the reference ALU
- f_ref_i  in  4  NZVC of the reference ALU, same bit order as f_dut_i
- busy  out  1  high while a run is in progress
- done  out  1  high from the end of a run until the next start or reset
- pass  out  1  done && err_count==0
- err_count  out  CNT_W  mismatching vectors; saturates at all-ones
- first_fail  out  19  {a,b,sel} of the first mismatching vector; 0 if there is none

## Operation
- Opcodes: 0 ADD, 1 INC, 2 SUB, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after the compare of vector NUM_VECTORS-1.
  - DONE -> RUN on start (restart).
  - start in RUN is ignored.
- Stimulus uses a 16-bit Fibonacci LFSR that shifts left: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Vector k: a_o=lfsr[15:8], b_o=lfsr[7:0], sel_o=k[2:0]. The LFSR advances once per vector.
- On entry to RUN:
  - LFSR reloads SEED and the vector index clears.
  - err_count and first_fail clear.
  - done drops.
- Compare: a vector mismatches when (r_dut_i != r_ref_i) or (f_dut_i != f_ref_i). Both are sampled the edge after the vector is driven, so the ALUs are treated as combinational.
- On a mismatch, err_count increments and holds at 2^CNT_W-1. first_fail is captured only when err_count was 0.
- Stimulus outputs hold the last vector in DONE and are 0 in IDLE.

## Timing
- Reset values: a_o, b_o, sel_o = 0; busy, done, pass = 0; err_count = 0; first_fail = 0; state = IDLE; LFSR = SEED.
- Edge E0 accepts start: busy=1 and vector 0 appears on a_o/b_o/sel_o.
- Vector k is driven at E(k) and compared at E(k+1). The pipeline is one stage deep, and compare and drive overlap.
- At E(NUM_VECTORS), after the final compare: busy=0, done=1, and err_count/pass are final. A run therefore lasts NUM_VECTORS+1 edges from start acceptance.
- A start in DONE at edge E restarts with the same timing; done falls at E.
- Asserting rst_n low mid-run returns all state to reset values immediately. The run is abandoned and no partial status is retained.
- NUM_VECTORS=1: done rises at E1.

## Structure
- Package alu_bist_pkg holds:
  - opcode constants;
  - NZVC bit-index constants (N_BIT=3, Z_BIT=2, V_BIT=1, C_BIT=0);
  - the state enum;
  - the default SEED;
  - the LFSR tap positions.
- Sub-module lfsr16 has inputs clk, rst_n, load, seed, and en, and output q[15:0]. It is reused by other BIST blocks.
- The top level contains the FSM, the vector counter, the compare/capture logic, and the output registers.

## Test plan
- LFSR/stimulus: SEED=16'hACE1, start -> at E0 a_o=8'hAC, b_o=8'hE1, sel_o=0; at E1 a_o=8'h59, b_o=8'hC3, sel_o=1.
- Clean pair: both inputs fed by the same golden ALU model, NUM_VECTORS=16 -> done at E16, busy low, err_count=0, pass=1, first_fail=0.
- Injected fault: DUT result = ref result ^ 8'h01 only when sel=3, NUM_VECTORS=64 -> err_count=8, pass=0, first_fail={8'hxx,8'hxx,3'd3} matching the vector-3 operands, captured at E4.
- Saturation: DUT flags inverted on every vector, CNT_W=8, NUM_VECTORS=300 -> err_count=255 at done.
- Control: start pulsed during RUN -> no effect, and done still rises at E(NUM_VECTORS). Start pulsed in DONE -> restart from SEED with err_count cleared.
- Reset mid-run: rst_n low at E5 of a 64-vector run -> all outputs 0 and state IDLE. A following start runs 64 vectors normally.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared opcodes, flag indices, FSM states and LFSR rule for the ALU BIST.
package alu_bist_pkg;
  localparam logic [2:0] OP_ADD = 3'd0, OP_INC = 3'd1, OP_SUB = 3'd2, OP_DEC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_XOR = 3'd6, OP_NOT = 3'd7;
  localparam int N_BIT = 3, Z_BIT = 2, V_BIT = 1, C_BIT = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/alu_bist_lfsr16.sv
// lfsr16: 16-bit left-shifting Fibonacci LFSR with synchronous load and step enable.
module lfsr16
  import alu_bist_pkg::*;
#(
  parameter logic [15:0] RST_VAL = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RST_VAL;
    else if (load) q <= seed;
    else if (en) q <= lfsr_next(q);
endmodule

// File: rtl/alu_bist.sv
// alu_bist: drives pseudo-random vectors to an ALU pair and compares their results one edge later.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [15:0] SEED        = DEFAULT_SEED,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [7:0]       a_o,
  output logic [7:0]       b_o,
  output logic [2:0]       sel_o,
  input  logic [7:0]       r_dut_i,
  input  logic [3:0]       f_dut_i,
  input  logic [7:0]       r_ref_i,
  input  logic [3:0]       f_ref_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [18:0]      first_fail
);
  state_e             state_q, state_d;
  logic [15:0]        idx_q, idx_d, lfsr_q, nxt;
  logic [7:0]         a_q, a_d, b_q, b_d;
  logic [2:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [18:0]        ff_q, ff_d;
  logic               lfsr_load, lfsr_en, mismatch, last;

  lfsr16 #(.RST_VAL(SEED)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .load(lfsr_load), .seed(SEED), .en(lfsr_en), .q(lfsr_q)
  );

  // The LFSR holds the vector currently on a_o/b_o, so the next vector is one step ahead.
  assign nxt      = lfsr_next(lfsr_q);
  assign mismatch = (r_dut_i != r_ref_i) || (f_dut_i != f_ref_i);
  assign last     = idx_q == 16'(NUM_VECTORS - 1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    err_d     = err_q;
    ff_d      = ff_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    if (state_q == ST_RUN) begin
      if (mismatch) begin
        err_d = &err_q ? err_q : err_q + CNT_W'(1);
        ff_d  = err_q == '0 ? {a_q, b_q, sel_q} : ff_q;
      end
      if (last) state_d = ST_DONE;
      else begin
        idx_d      = idx_q + 16'd1;
        lfsr_en    = 1'b1;
        {a_d, b_d} = nxt;
        sel_d      = sel_q + 3'd1;
      end
    end else if (start) begin
      state_d    = ST_RUN;
      idx_d      = '0;
      err_d      = '0;
      ff_d       = '0;
      lfsr_load  = 1'b1;
      {a_d, b_d} = SEED;
      sel_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign sel_o      = sel_q;
  assign busy       = state_q == ST_RUN;
  assign done       = state_q == ST_DONE;
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
  assign first_fail = ff_q;
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: golden-ALU pair around two BIST instances, checked against an elapsed-edge model.
module tb_alu_bist;
  import alu_bist_pkg::*;
  localparam int N = 64, NS = 300;
  logic clk = 0, rst_n = 0, start = 0, fault = 0;
  always #5 clk = ~clk;

  logic [7:0] a, b, rr, rd, sa, sb, srr;
  logic [2:0] sel, ssel;
  logic [3:0] fr, sfr;
  logic busy, done, pass, s_busy, s_done, s_pass;
  logic [7:0] errc, s_errc;
  logic [18:0] ff, s_ff;
  logic [15:0] vec [NS];
  int n_cmp = 0, n_bad = 0;

  function automatic logic [11:0] alu(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    logic [8:0] w;
    logic [7:0] yy;
    logic [3:0] f;
    logic sub;
    yy  = (op == OP_INC || op == OP_DEC) ? 8'd1 : y;
    sub = op == OP_SUB || op == OP_DEC;
    w   = sub ? {1'b0, x} - {1'b0, yy} : {1'b0, x} + {1'b0, yy};
    f   = '0;
    if (op <= OP_DEC) begin
      f[C_BIT] = w[8];
      f[V_BIT] = sub ? (x[7] != yy[7]) && (w[7] != x[7]) : (x[7] == yy[7]) && (w[7] != x[7]);
    end else
      w = {1'b0, op == OP_AND ? x & y : op == OP_OR ? x | y : op == OP_XOR ? x ^ y : ~x};
    f[N_BIT] = w[7];
    f[Z_BIT] = w[7:0] == 8'd0;
    return {w[7:0], f};
  endfunction

  always_comb {rr, fr} = alu(a, b, sel);
  always_comb {srr, sfr} = alu(sa, sb, ssel);
  assign rd = rr ^ {7'd0, fault && sel == 3'd3};

  alu_bist #(.NUM_VECTORS(N), .SEED(16'hACE1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_o(a), .b_o(b), .sel_o(sel),
    .r_dut_i(rd), .f_dut_i(fr), .r_ref_i(rr), .f_ref_i(fr),
    .busy(busy), .done(done), .pass(pass), .err_count(errc), .first_fail(ff)
  );

  alu_bist #(.NUM_VECTORS(NS), .SEED(16'hACE1), .CNT_W(8)) sat (
    .clk(clk), .rst_n(rst_n), .start(start), .a_o(sa), .b_o(sb), .sel_o(ssel),
    .r_dut_i(srr), .f_dut_i(~sfr), .r_ref_i(srr), .f_ref_i(sfr),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_errc), .first_fail(s_ff)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: outputs follow from how many edges have elapsed since the run was accepted.
  int cyc = 0;
  bit started = 0, run_fault = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      started <= 0;
      cyc     <= 0;
    end else if (start && (!started || cyc >= N)) begin
      started   <= 1;
      cyc       <= 0;
      run_fault <= fault;
    end else if (started && cyc < N) cyc <= cyc + 1;

  always @(negedge clk) begin
    int k, nb;
    logic [18:0] ef;
    nb = 0;
    ef = '0;
    if (started)
      for (int j = 0; j < cyc && j < N; j++)
        if (run_fault && j % 8 == 3) begin
          if (nb == 0) ef = {vec[j], 3'(j)};
          nb++;
        end
    k = cyc < N ? cyc : N - 1;
    chk("a_o", 32'(a), started ? 32'(vec[k][15:8]) : 0);
    chk("b_o", 32'(b), started ? 32'(vec[k][7:0]) : 0);
    chk("sel_o", 32'(sel), started ? 32'(k % 8) : 0);
    chk("busy", 32'(busy), 32'(started && cyc < N));
    chk("done", 32'(done), 32'(started && cyc >= N));
    chk("pass", 32'(pass), 32'(started && cyc >= N && nb == 0));
    chk("err_count", 32'(errc), 32'(nb > 255 ? 255 : nb));
    chk("first_fail", 32'(ff), 32'(ef));
  end

  task automatic pulse_start();
    @(negedge clk); #2 start = 1;
    @(negedge clk); #2 start = 0;
  endtask

  task automatic wait_done(input int bound, output int edges);
    edges = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (done) begin edges = i; break; end
    end
    if (edges < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int e;
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < NS; i++) begin
      vec[i] = l;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    repeat (3) @(negedge clk);
    chk("reset_a_o", 32'(a), 0);
    chk("reset_done", 32'(done), 0);
    #2 rst_n = 1;
    // Clean run, with a start pulse mid-run that must be ignored.
    pulse_start();
    chk("e0_a", 32'(a), 32'h AC);
    chk("e0_b", 32'(b), 32'h E1);
    chk("e0_sel", 32'(sel), 0);
    @(negedge clk);
    chk("e1_a", 32'(a), 32'h59);
    chk("e1_b", 32'(b), 32'h C3);
    chk("e1_sel", 32'(sel), 1);
    repeat (8) @(negedge clk);
    pulse_start();
    wait_done(200, e);
    chk("clean_pass", 32'(pass), 1);
    chk("clean_err", 32'(errc), 0);
    chk("clean_ff", 32'(ff), 0);
    // Saturating counter on the 300-vector instance.
    for (int i = 0; i < 400 && !s_done; i++) @(negedge clk);
    chk("sat_done", 32'(s_done), 1);
    chk("sat_err", 32'(s_errc), 255);
    chk("sat_pass", 32'(s_pass), 0);
    chk("sat_ff", 32'(s_ff), {13'd0, 16'hACE1, 3'd0});
    // Injected fault on opcode 3, restarted from DONE.
    #1 fault = 1;
    pulse_start();
    wait_done(200, e);
    chk("fault_done_edge", 32'(e), N);
    chk("fault_err", 32'(errc), 8);
    chk("fault_pass", 32'(pass), 0);
    chk("fault_ff", 32'(ff), {13'd0, 8'h67, 8'h0F, 3'd3});
    #1 fault = 0;
    pulse_start();
    chk("restart_err", 32'(errc), 0);
    chk("restart_done", 32'(done), 0);
    // Reset in the middle of a run.
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_a", 32'(a), 0);
    chk("rst_sel", 32'(sel), 0);
    #2 rst_n = 1;
    pulse_start();
    wait_done(200, e);
    chk("post_rst_edge", 32'(e), N);
    chk("post_rst_pass", 32'(pass), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
